// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the ID/EX/WB hazard and forwarding controller:
//   - EX result-class encodings carried on md_ex
//   - controller FSM state encoding
//   - default register-address width and stall-counter width
//   - saturating 16-bit increment used by the optional statistics counters
//     (HAZ_STATS_EN)
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int AW_DEF = 5;

   // Wide enough for the largest legal multi-cycle latency (15).
   localparam int CNT_W = 4;

   localparam logic [1:0] MD_ALU  = 2'b00;
   localparam logic [1:0] MD_LOAD = 2'b01;
   localparam logic [1:0] MD_MUL  = 2'b10;
   localparam logic [1:0] MD_RSV  = 2'b11;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      MULBUSY = 2'd2
   } hz_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the pipeline-facing signals of the hazard controller.
//   slave  : the controller (hazard_ctrl) - consumes ID/EX/WB status,
//            produces forward selects and stall/bubble/flush.
//   master : the pipeline (or a testbench) - the mirror image.
// Signals:
//   sa_id, sb_id   ID source registers          ma_id, mb_id  operand not a register
//   da_ex, rw_ex   EX destination / write flag  md_ex         EX result class
//   da_wb, rw_wb   WB destination / write flag  branch_taken  EX taken branch
//   ex_hazard_a/b, wb_hazard_a/b  registered forward selects
//   stall, bubble, flush          combinational pipeline controls
//   stall_cnt, fwd_cnt            statistics, only with HAZ_STATS_EN
// ---------------------------------------------------------------------------
interface hazard_ctrl_if import pipe_pkg::*; #(
   parameter int AW = AW_DEF
) ();

   logic [AW-1:0] sa_id;
   logic [AW-1:0] sb_id;
   logic          ma_id;
   logic          mb_id;
   logic [AW-1:0] da_ex;
   logic          rw_ex;
   logic [1:0]    md_ex;
   logic [AW-1:0] da_wb;
   logic          rw_wb;
   logic          branch_taken;

   logic          ex_hazard_a;
   logic          wb_hazard_a;
   logic          ex_hazard_b;
   logic          wb_hazard_b;
   logic          stall;
   logic          bubble;
   logic          flush;
`ifdef HAZ_STATS_EN
   logic [15:0]   stall_cnt;
   logic [15:0]   fwd_cnt;
`endif

   modport slave (
      input  sa_id, sb_id, ma_id, mb_id, da_ex, rw_ex, md_ex, da_wb, rw_wb,
             branch_taken,
`ifdef HAZ_STATS_EN
      output stall_cnt, fwd_cnt,
`endif
      output ex_hazard_a, wb_hazard_a, ex_hazard_b, wb_hazard_b,
             stall, bubble, flush
   );

   modport master (
      output sa_id, sb_id, ma_id, mb_id, da_ex, rw_ex, md_ex, da_wb, rw_wb,
             branch_taken,
`ifdef HAZ_STATS_EN
      input  stall_cnt, fwd_cnt,
`endif
      input  ex_hazard_a, wb_hazard_a, ex_hazard_b, wb_hazard_b,
             stall, bubble, flush
   );

endinterface

// File: rtl/hazard_ctrl_cmp.sv
// ---------------------------------------------------------------------------
// hazard_cmp
// Per-operand dependency comparator. Flags whether the ID source register
// matches the register being written by the instruction in EX and/or WB.
// Register 0 and non-register operands (PC / immediate) never match.
// Ports:
//   src_i     ID source register        no_reg_i  operand is PC/immediate
//   da_ex_i   EX destination            rw_ex_i   EX writes register file
//   da_wb_i   WB destination            rw_wb_i   WB writes register file
//   hit_ex_o  dependency on EX result   hit_wb_o  dependency on WB result
// ---------------------------------------------------------------------------
module hazard_cmp import pipe_pkg::*; #(
   parameter int AW = AW_DEF
) (
   input  logic [AW-1:0] src_i,
   input  logic          no_reg_i,
   input  logic [AW-1:0] da_ex_i,
   input  logic          rw_ex_i,
   input  logic [AW-1:0] da_wb_i,
   input  logic          rw_wb_i,
   output logic          hit_ex_o,
   output logic          hit_wb_o
);

   logic src_valid_s;

   // Source qualifies for hazard checking only if it is a real, non-zero register.
   always_comb begin
      src_valid_s = (src_i != {AW{1'b0}}) & ~no_reg_i;
      hit_ex_o    = rw_ex_i & (da_ex_i == src_i) & src_valid_s;
      hit_wb_o    = rw_wb_i & (da_wb_i == src_i) & src_valid_s;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard and forwarding controller for the 3-stage ID/EX/WB pipeline.
//   - Compares ID sources against EX/WB destinations (two hazard_cmp).
//   - Registers the forward selects into EX; EX forward wins in the mux.
//   - FSM RUN/LDSTALL/MULBUSY sequences load-use and multi-cycle stalls.
//   - A taken branch flushes IF/ID, bubbles ID/EX and aborts any stall.
// Ports:
//   clk    pipeline clock
//   rst_n  asynchronous reset, ACTIVE-HIGH despite its name
//   bus    hazard_ctrl_if.slave (see interface header for signal list)
// Parameters:
//   AW       register address width
//   MUL_LAT  EX cycles occupied by a multi-cycle op, legal 2..15;
//            the pipeline is stalled for MUL_LAT-1 of them.
// Optional build macro HAZ_STATS_EN adds saturating stall_cnt / fwd_cnt.
// ---------------------------------------------------------------------------
module hazard_ctrl import pipe_pkg::*; #(
   parameter int AW      = AW_DEF,
   parameter int MUL_LAT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  bus
);

   logic             hit_ex_a_s;
   logic             hit_wb_a_s;
   logic             hit_ex_b_s;
   logic             hit_wb_b_s;

   hz_state_e        state_q;
   hz_state_e        state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic             stall_load_s;
   logic             mul_stall_s;
   logic             stall_s;
   logic             bubble_s;
   logic             flush_s;

   // Forward selects packed as {ex_a, wb_a, ex_b, wb_b}.
   logic [3:0]       fwd_q;
   logic [3:0]       fwd_d;

   hazard_cmp #(.AW(AW)) u_cmp_a (
      .src_i    (bus.sa_id),
      .no_reg_i (bus.ma_id),
      .da_ex_i  (bus.da_ex),
      .rw_ex_i  (bus.rw_ex),
      .da_wb_i  (bus.da_wb),
      .rw_wb_i  (bus.rw_wb),
      .hit_ex_o (hit_ex_a_s),
      .hit_wb_o (hit_wb_a_s)
   );

   hazard_cmp #(.AW(AW)) u_cmp_b (
      .src_i    (bus.sb_id),
      .no_reg_i (bus.mb_id),
      .da_ex_i  (bus.da_ex),
      .rw_ex_i  (bus.rw_ex),
      .da_wb_i  (bus.da_wb),
      .rw_wb_i  (bus.rw_wb),
      .hit_ex_o (hit_ex_b_s),
      .hit_wb_o (hit_wb_b_s)
   );

   // FSM next-state, stall counter and stall causes.
   // The multi-cycle stall is driven from the counter's next value: the
   // detection cycle stalls and the op leaves EX on the cycle the count
   // reaches 0, giving MUL_LAT-1 stalled cycles in total.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stall_load_s = 1'b0;
      mul_stall_s  = 1'b0;
      if (bus.branch_taken) begin
         // Taken branch wins over everything: abort any stall sequence.
         state_d = RUN;
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            RUN: begin
               if ((bus.md_ex == MD_LOAD) && (hit_ex_a_s || hit_ex_b_s)) begin
                  stall_load_s = 1'b1;
                  state_d      = LDSTALL;
               end else if (bus.md_ex == MD_MUL) begin
                  cnt_d       = CNT_W'(MUL_LAT - 1);
                  mul_stall_s = (cnt_d != {CNT_W{1'b0}});
                  state_d     = MULBUSY;
               end else begin
                  state_d = RUN;
               end
            end
            LDSTALL: begin
               // Load is now in WB; WB forwarding covers the operand.
               state_d = RUN;
            end
            MULBUSY: begin
               if (cnt_q != {CNT_W{1'b0}}) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  cnt_d = {CNT_W{1'b0}};
               end
               mul_stall_s = (cnt_d != {CNT_W{1'b0}});
               if (cnt_d == {CNT_W{1'b0}}) begin
                  state_d = RUN;
               end else begin
                  state_d = MULBUSY;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Pipeline control outputs; all forced low while reset is asserted.
   always_comb begin
      stall_s  = 1'b0;
      bubble_s = 1'b0;
      flush_s  = 1'b0;
      if (rst_n) begin
         stall_s  = 1'b0;
         bubble_s = 1'b0;
         flush_s  = 1'b0;
      end else begin
         flush_s  = bus.branch_taken;
         bubble_s = bus.branch_taken | stall_load_s;
         stall_s  = stall_load_s | mul_stall_s;
      end
   end

   // Next forward selects; a bubbled or flushed slot carries no forwarding.
   always_comb begin
      fwd_d = 4'b0000;
      if (bubble_s || flush_s) begin
         fwd_d = 4'b0000;
      end else begin
         fwd_d = {hit_ex_a_s & ~stall_load_s, hit_wb_a_s,
                  hit_ex_b_s & ~stall_load_s, hit_wb_b_s};
      end
   end

   // State, counter and forward-select registers.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= RUN;
         cnt_q   <= {CNT_W{1'b0}};
         fwd_q   <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fwd_q   <= fwd_d;
      end
   end

   assign bus.ex_hazard_a = fwd_q[3];
   assign bus.wb_hazard_a = fwd_q[2];
   assign bus.ex_hazard_b = fwd_q[1];
   assign bus.wb_hazard_b = fwd_q[0];
   assign bus.stall       = stall_s;
   assign bus.bubble      = bubble_s;
   assign bus.flush       = flush_s;

`ifdef HAZ_STATS_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] fwd_cnt_q;

   // Saturating event counters for stall cycles and forwarding cycles.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         stall_cnt_q <= 16'd0;
         fwd_cnt_q   <= 16'd0;
      end else begin
         if (stall_s) begin
            stall_cnt_q <= sat_inc16(stall_cnt_q);
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
         if (fwd_q != 4'b0000) begin
            fwd_cnt_q <= sat_inc16(fwd_cnt_q);
         end else begin
            fwd_cnt_q <= fwd_cnt_q;
         end
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed, table-driven bench for hazard_ctrl (AW=5, MUL_LAT=4), plus
// hand-written sequences for multi-cycle stall, branch abort and reset.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
   import pipe_pkg::*;

   logic clk;
   logic rst_n;

   hazard_ctrl_if #(.AW(5)) bus ();

   hazard_ctrl #(.AW(5), .MUL_LAT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [4:0] sa;
      logic [4:0] sb;
      logic       ma;
      logic       mb;
      logic [4:0] da_ex;
      logic       rw_ex;
      logic [1:0] md;
      logic [4:0] da_wb;
      logic       rw_wb;
      logic       br;
      logic       e_stall;
      logic       e_bubble;
      logic       e_flush;
      logic [3:0] e_fwd;   // {ex_a, wb_a, ex_b, wb_b} after the edge
   } vec_t;

   vec_t vecs [20];
   int   total;
   int   passed;

   function automatic vec_t mk(input logic [4:0] sa, input logic [4:0] sb,
                               input logic ma, input logic mb,
                               input logic [4:0] da_ex, input logic rw_ex,
                               input logic [1:0] md, input logic [4:0] da_wb,
                               input logic rw_wb, input logic br,
                               input logic es, input logic eb, input logic ef,
                               input logic [3:0] efwd);
      vec_t v;
      v.sa = sa; v.sb = sb; v.ma = ma; v.mb = mb;
      v.da_ex = da_ex; v.rw_ex = rw_ex; v.md = md;
      v.da_wb = da_wb; v.rw_wb = rw_wb; v.br = br;
      v.e_stall = es; v.e_bubble = eb; v.e_flush = ef; v.e_fwd = efwd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.sa_id = v.sa;  bus.sb_id = v.sb;
      bus.ma_id = v.ma;  bus.mb_id = v.mb;
      bus.da_ex = v.da_ex; bus.rw_ex = v.rw_ex; bus.md_ex = v.md;
      bus.da_wb = v.da_wb; bus.rw_wb = v.rw_wb;
      bus.branch_taken = v.br;
   endtask

   task automatic idle();
      drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 4'b0000));
   endtask

   function automatic logic [3:0] fwd_now();
      return {bus.ex_hazard_a, bus.wb_hazard_a, bus.ex_hazard_b, bus.wb_hazard_b};
   endfunction

   function automatic logic [3:0] ctl_now();
      return {1'b0, bus.stall, bus.bubble, bus.flush};
   endfunction

   initial begin
      vec_t v;
      total  = 0;
      passed = 0;

      //        sa     sb     ma    mb    da_ex  rw    md     da_wb  rwwb  br    st    bu    fl    fwd
      vecs[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      vecs[1]  = mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
      vecs[2]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      vecs[3]  = mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      vecs[4]  = mk(5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 2'b00, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100);
      vecs[5]  = mk(5'd0, 5'd12,1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd12,1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
      vecs[6]  = mk(5'd0, 5'd12,1'b0, 1'b1, 5'd12,1'b1, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      vecs[7]  = mk(5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      // load-use on B, then the load sits in WB
      vecs[8]  = mk(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
      vecs[9]  = mk(5'd0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
      vecs[10] = mk(5'd2, 5'd3, 1'b0, 1'b0, 5'd6, 1'b1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      vecs[11] = mk(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
      // taken branch: flush+bubble, no stall, selects cleared
      vecs[12] = mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
      vecs[13] = mk(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
      // still RUN after branch: load-use detected again
      vecs[14] = mk(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
      vecs[15] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      vecs[16] = mk(5'd10,5'd10,1'b0, 1'b0, 5'd10,1'b1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
      vecs[17] = mk(5'd10,5'd10,1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd10,1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101);
      vecs[18] = mk(5'd6, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      vecs[19] = mk(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

      // Reset: controls stay low even with load-use and branch present.
      rst_n = 1'b1;
      drive(vecs[13]);
      repeat (2) @(posedge clk);
      #1;
      chk("reset ctl", ctl_now(), 4'b0000);
      chk("reset fwd", fwd_now(), 4'b0000);
      idle();
      rst_n = 1'b0;

      for (int i = 0; i < 20; i++) begin
         v = vecs[i];
         drive(v);
         #3;
         chk($sformatf("vec%0d ctl", i), ctl_now(), {1'b0, v.e_stall, v.e_bubble, v.e_flush});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d fwd", i), fwd_now(), v.e_fwd);
      end

      // Multi-cycle op: op occupies EX 4 cycles, stall high for the first 3.
      for (int c = 0; c < 6; c++) begin
         logic [3:0] exp_ctl;
         idle();
         bus.da_ex = 5'd11;
         bus.rw_ex = 1'b1;
         bus.md_ex = (c < 4) ? MD_MUL : MD_ALU;
         exp_ctl   = (c < 3) ? 4'b0100 : 4'b0000;
         #3;
         chk($sformatf("mul c%0d", c), ctl_now(), exp_ctl);
         @(posedge clk);
         #1;
      end

      // Branch taken on cycle 2 of a multi-cycle stall aborts it.
      for (int c = 0; c < 5; c++) begin
         logic [3:0] exp_ctl;
         idle();
         case (c)
            0, 1: begin
               bus.da_ex = 5'd11; bus.rw_ex = 1'b1; bus.md_ex = MD_MUL;
               exp_ctl = 4'b0100;
            end
            2: begin
               bus.da_ex = 5'd11; bus.rw_ex = 1'b1; bus.md_ex = MD_MUL;
               bus.branch_taken = 1'b1;
               exp_ctl = 4'b0011;
            end
            3: begin
               // only a RUN-state controller reports a load-use here
               bus.sb_id = 5'd5; bus.da_ex = 5'd5; bus.rw_ex = 1'b1; bus.md_ex = MD_LOAD;
               exp_ctl = 4'b0110;
            end
            default: begin
               exp_ctl = 4'b0000;
            end
         endcase
         #3;
         chk($sformatf("brmul c%0d", c), ctl_now(), exp_ctl);
         @(posedge clk);
         #1;
      end

      // Asynchronous reset in the middle of a multi-cycle stall.
      idle();
      bus.da_ex = 5'd11; bus.rw_ex = 1'b1; bus.md_ex = MD_MUL;
      #3;
      chk("rstmul start", ctl_now(), 4'b0100);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rstmul in reset", ctl_now(), 4'b0000);
      @(posedge clk);
      #1;
      idle();
      rst_n = 1'b0;
      bus.sa_id = 5'd5; bus.da_ex = 5'd5; bus.rw_ex = 1'b1; bus.md_ex = MD_LOAD;
      #3;
      chk("rstmul run", ctl_now(), 4'b0110);
      @(posedge clk);
      #1;
      idle();
      @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 3-stage ID/EX/WB integer pipeline.
- Compares ID-stage source registers against the in-flight EX and WB destinations.
- Registers the forwarding selects (ex_hazard_a/b, wb_hazard_a/b) into EX for the operand-A/B muxes.
- Sequences load-use and multi-cycle stalls, bubbles and branch flushes.

Parameters:
- AW, 5, register address width.
- MUL_LAT, 4, EX cycles a multi-cycle op (md_ex==2'b10) occupies; legal range 2..15.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous reset, active-high (1 = reset) despite the name.
- sa_id  in  AW  ID source register A.
- sb_id  in  AW  ID source register B.
- ma_id  in  1  ID operand A is PC (no A hazard).
- mb_id  in  1  ID operand B is immediate (no B hazard).
- da_ex  in  AW  EX destination register.
- rw_ex  in  1  EX instruction writes register file.
- md_ex  in  2  EX result class: 00 ALU, 01 load, 10 multi-cycle, 11 reserved (treated as ALU).
- da_wb  in  AW  WB destination register.
- rw_wb  in  1  WB writes register file.
- branch_taken  in  1  EX resolved taken branch.
- ex_hazard_a  out  1  EX-stage select: forward EX result to A (registered).
- wb_hazard_a  out  1  EX-stage select: forward BUS_D to A (registered).
- ex_hazard_b  out  1  as ex_hazard_a, operand B.
- wb_hazard_b  out  1  as wb_hazard_a, operand B.
- stall  out  1  hold PC and IF/ID (combinational).
- bubble  out  1  load NOP into ID/EX (combinational).
- flush  out  1  kill IF/ID contents (combinational).

Behaviour:
- Reset: all registered outputs 0, FSM = RUN, mul counter 0; stall/bubble/flush 0 while in reset.
- Match definition:
  - hitEX_A = rw_ex & (da_ex==sa_id) & (sa_id!=0) & !ma_id.
  - hitWB_A = rw_wb & (da_wb==sa_id) & (sa_id!=0) & !ma_id.
  - B uses sb_id and mb_id.
  - R0 never hazards.
- Forward selects:
  - Registered on clk: ex_hazard_x <= hitEX_x & !stall_load.
  - wb_hazard_x <= hitWB_x.
  - Both may be 1; the EX mux gives EX priority.
  - If bubble or flush is 1, all four register 0 next cycle.
- FSM states RUN, LDSTALL, MULBUSY:
  - RUN -> LDSTALL when md_ex==01 & (hitEX_A|hitEX_B): stall=1 and bubble=1 this cycle.
  - LDSTALL -> RUN unconditionally; the next cycle the load is in WB, so wb_hazard is captured normally.
  - RUN -> MULBUSY when md_ex==10: counter loads MUL_LAT-1; stall=1 and bubble=0 while the counter is nonzero.
  - MULBUSY -> RUN when the counter reaches 0; total stall = MUL_LAT-1 cycles.
- branch_taken:
  - flush=1 and bubble=1 the same cycle; highest priority.
  - Aborts LDSTALL/MULBUSY back to RUN with counter cleared.
  - stall=0 that cycle.
- Simultaneous load-use and multi-cycle cannot occur: md_ex is a single value.
- Reset mid-stall returns to RUN immediately (async).

Optional Feature:
- HAZ_STATS_EN defined: adds outputs stall_cnt[15:0] and fwd_cnt[15:0].
  - stall_cnt increments each cycle stall=1; fwd_cnt increments each cycle any registered hazard output is 1.
  - Both saturate at 16'hFFFF; reset 0.
- HAZ_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg: MD_ALU/MD_LOAD/MD_MUL/MD_RSV 2-bit constants, FSM state encoding (RUN=0, LDSTALL=1, MULBUSY=2), AW default.
- One natural sub-module: hazard_cmp, the per-operand comparator (instantiated twice, for A and B) producing hitEX/hitWB.

Test Plan:
- ALU back-to-back: EX da_ex=3,rw_ex=1,md_ex=00; ID sa_id=3 -> next cycle ex_hazard_a=1, stall=0.
- Load-use: md_ex=01,da_ex=5; sb_id=5 -> stall=1,bubble=1 one cycle; following cycle (da_wb=5,rw_wb=1) wb_hazard_b=1, ex_hazard_b=0.
- Multi-cycle MUL_LAT=4: md_ex=10 -> stall high exactly 3 cycles, then RUN.
- Branch during MULBUSY at cycle 2: branch_taken=1 -> flush=1,bubble=1,stall=0; FSM RUN next cycle.
- R0/PC guard: sa_id=0 with da_ex=0,rw_ex=1 -> no hazard; sa_id=7,ma_id=1,da_ex=7 -> ex_hazard_a=0.
- Double match: da_ex=da_wb=sa_id=9, both rw=1 -> ex_hazard_a=1 and wb_hazard_a=1.
